// File: rtl/ber_pkg.sv
// Shared types and constants for the bit-error-rate tester.
package ber_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ber_state_t;

   localparam logic       MODE_ALT    = 1'b0;
   localparam logic       MODE_PRBS7  = 1'b1;
   localparam logic [6:0] PRBS7_SEED  = 7'h7F;
   localparam int         PRBS7_TAP_A = 6;
   localparam int         PRBS7_TAP_B = 5;

endpackage

// File: rtl/ber_tester_if.sv
// Pin-side bundle of the BER tester: controls and returned signal in, pattern/counts/status out.
interface ber_tester_if #(parameter int COUNT_W = 10);
   import ber_pkg::*;

   // No valid/ready handshake: start_n is a level button whose falling edge is the start event,
   // all other controls are levels sampled when the FSM needs them.
   logic               start_n;
   logic               run;
   logic               mode;
   logic [COUNT_W-1:0] test_len;
   logic               rx_in;
   logic               tx_out;
   logic [COUNT_W-1:0] err_count;
   logic [COUNT_W-1:0] bit_count;
   logic               busy;
   logic               done;
   logic               err_sat;
   ber_state_t         state;

   modport master (
      output start_n, run, mode, test_len, rx_in,
      input  tx_out, err_count, bit_count, busy, done, err_sat, state
   );

   modport slave (
      input  start_n, run, mode, test_len, rx_in,
      output tx_out, err_count, bit_count, busy, done, err_sat, state
   );

endinterface

// File: rtl/ber_pattern_gen.sv
// Test-pattern source: alternating 1,0,1,... or PRBS7 (x^7+x^6+1); bit_out is the next bit to launch.
module ber_pattern_gen
   import ber_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic advance,
   input  logic mode,
   output logic bit_out
);

   logic [6:0] lfsr;
   logic       alt_next;
   logic       prbs_new;

   assign prbs_new = lfsr[PRBS7_TAP_A] ^ lfsr[PRBS7_TAP_B];
   assign bit_out  = (mode == MODE_PRBS7) ? prbs_new : alt_next;

   // Both generators step together; only the selected one is visible.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr     <= PRBS7_SEED;
         alt_next <= 1'b1;
      end else if (load) begin
         lfsr     <= PRBS7_SEED;
         alt_next <= 1'b1;
      end else if (advance) begin
         lfsr     <= {lfsr[5:0], prbs_new};
         alt_next <= ~alt_next;
      end
   end

endmodule

// File: rtl/ber_tester.sv
// BER tester top: start/rx synchronisers, bit-period timer, expected-bit delay line,
// saturating counters and the IDLE/RUN/DONE controller.
module ber_tester
   import ber_pkg::*;
#(
   parameter int CLK_DIV       = 250,
   parameter int SAMPLE_OFFSET = 125,
   parameter int LOOP_DELAY    = 0,
   parameter int COUNT_W       = 10
) (
   input  logic         clk,
   input  logic         reset_n,
   ber_tester_if.slave  bus
);

   localparam int                 TIMER_W      = $clog2(CLK_DIV);
   localparam logic [TIMER_W-1:0] TIMER_LAST   = TIMER_W'(CLK_DIV - 1);
   localparam logic [TIMER_W-1:0] TIMER_SAMPLE = TIMER_W'(SAMPLE_OFFSET);
   localparam logic [4:0]         LAUNCH_MAX   = 5'd16;
   localparam logic [4:0]         LAUNCH_NEED  = 5'(LOOP_DELAY);
   localparam logic [COUNT_W-1:0] COUNT_MAX    = '1;

   ber_state_t         state;
   logic [TIMER_W-1:0] timer;
   logic               start_s1, start_s2, start_prev;
   logic               rx_s1, rx_s2;
   logic               mode_q, tx_q, busy_q, done_q, err_sat_q;
   logic [LOOP_DELAY:0] exp_sr;
   logic [4:0]         launch_cnt;
   logic [COUNT_W-1:0] err_cnt, bit_cnt;
   logic [COUNT_W-1:0] err_next, bit_next;
   logic               start_ev, pat_load, pat_advance, pat_bit, do_compare, mismatch;

   assign start_ev    = start_prev & ~start_s2;
   assign pat_load    = start_ev && (state != RUN);
   assign pat_advance = (state == RUN) && (timer == '0);
   // Compare only once the delay line holds the bit that is now returning.
   assign do_compare  = (state == RUN) && (timer == TIMER_SAMPLE) && (launch_cnt > LAUNCH_NEED);
   assign mismatch    = rx_s2 != exp_sr[LOOP_DELAY];
   assign bit_next    = (bit_cnt == COUNT_MAX) ? bit_cnt : bit_cnt + 1'b1;
   assign err_next    = (mismatch && (err_cnt != COUNT_MAX)) ? err_cnt + 1'b1 : err_cnt;

   ber_pattern_gen u_pattern (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (pat_load),
      .advance (pat_advance),
      .mode    (mode_q),
      .bit_out (pat_bit)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start_s1   <= 1'b1;
         start_s2   <= 1'b1;
         start_prev <= 1'b1;
         rx_s1      <= 1'b0;
         rx_s2      <= 1'b0;
      end else begin
         start_s1   <= bus.start_n;
         start_s2   <= start_s1;
         start_prev <= start_s2;
         rx_s1      <= bus.rx_in;
         rx_s2      <= rx_s1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         timer      <= '0;
         mode_q     <= MODE_ALT;
         tx_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_sat_q  <= 1'b0;
         exp_sr     <= '0;
         launch_cnt <= '0;
         err_cnt    <= '0;
         bit_cnt    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               timer <= '0;
               tx_q  <= 1'b0;
               if (start_ev) begin
                  state      <= RUN;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  err_sat_q  <= 1'b0;
                  err_cnt    <= '0;
                  bit_cnt    <= '0;
                  launch_cnt <= '0;
                  mode_q     <= bus.mode;
               end
            end
            RUN: begin
               timer <= (timer == TIMER_LAST) ? '0 : timer + 1'b1;
               if (pat_advance) begin
                  tx_q      <= pat_bit;
                  exp_sr[0] <= pat_bit;
                  for (int i = 1; i <= LOOP_DELAY; i++) exp_sr[i] <= exp_sr[i-1];
                  if (launch_cnt != LAUNCH_MAX) launch_cnt <= launch_cnt + 5'd1;
               end
               if (do_compare) begin
                  bit_cnt <= bit_next;
                  err_cnt <= err_next;
                  if (err_next == COUNT_MAX) err_sat_q <= 1'b1;
                  if (!bus.run && ((bus.test_len == '0) || (bit_next >= bus.test_len))) begin
                     state  <= DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     tx_q   <= 1'b0;
                     timer  <= '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.tx_out    = tx_q;
   assign bus.err_count = err_cnt;
   assign bus.bit_count = bit_cnt;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err_sat   = err_sat_q;
   assign bus.state     = state;

endmodule

// File: tb/tb_ber_tester.sv
// Bench for ber_tester: three instances (plain, 2-period loop delay, 4-bit counters).
module tb_ber_tester;
   import ber_pkg::*;

   typedef struct {
      logic mode;
      int   len;
      int   kind;      // 0 loopback, 1 inverted, 2 rx stuck 0, 3 random flips
      int   exp_err;   // -1: take from the reference model
      int   exp_bits;
      int   n_first;
      int   first;
   } vec_t;

   logic clk = 1'b0;
   logic rst_a, rst_bc;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc_a, cyc_b;
   logic mon_a = 1'b0;
   logic force0_a = 1'b0;
   logic flip_a [1024];
   logic pat [1024];
   logic [0:0] exp_q[$];
   logic cap_q[$];
   logic [15:0] hist_b;
   vec_t vecs[$];

   ber_tester_if #(.COUNT_W(10)) if_a ();
   ber_tester_if #(.COUNT_W(10)) if_b ();
   ber_tester_if #(.COUNT_W(4))  if_c ();

   ber_tester #(.CLK_DIV(8), .SAMPLE_OFFSET(4), .LOOP_DELAY(0), .COUNT_W(10))
      u_a (.clk(clk), .reset_n(rst_a), .bus(if_a));
   ber_tester #(.CLK_DIV(8), .SAMPLE_OFFSET(4), .LOOP_DELAY(2), .COUNT_W(10))
      u_b (.clk(clk), .reset_n(rst_bc), .bus(if_b));
   ber_tester #(.CLK_DIV(8), .SAMPLE_OFFSET(4), .LOOP_DELAY(0), .COUNT_W(4))
      u_c (.clk(clk), .reset_n(rst_bc), .bus(if_c));

   // ---------------- clock / cycle tracking / loops ----------------
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc_a  <= if_a.busy ? cyc_a + 1 : 0;
      cyc_b  <= if_b.busy ? cyc_b + 1 : 0;
      hist_b <= {hist_b[14:0], if_b.tx_out};
   end

   assign if_a.rx_in = force0_a ? 1'b0 : (if_a.tx_out ^ flip_a[(cyc_a / 8) % 1024]);
   assign if_b.rx_in = hist_b[15];
   assign if_c.rx_in = ~if_c.tx_out;

   // ---------------- reference model / scoreboard ----------------
   task automatic build_pattern(input logic m);
      logic a, b;
      for (int n = 0; n < 1024; n++) begin
         if (m == MODE_ALT) pat[n] = (n % 2 == 0);
         else begin
            a = (n >= 7) ? pat[n-7] : 1'b1;
            b = (n >= 6) ? pat[n-6] : 1'b1;
            pat[n] = a ^ b;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_a && if_a.busy && (cyc_a % 8 == 4)) begin
         cap_q.push_back(if_a.tx_out);
         if (exp_q.size() != 0) check("tx_bit", 32'(if_a.tx_out), 32'(exp_q.pop_front()));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_start(input int w, input logic v);
      case (w)
         0:       if_a.start_n = v;
         1:       if_b.start_n = v;
         default: if_c.start_n = v;
      endcase
   endtask

   task automatic pulse_start(input int w);
      set_start(w, 1'b0);
      repeat (3) @(negedge clk);
      set_start(w, 1'b1);
   endtask

   task automatic wait_cyc(input int w, input int target);
      int guard = 0;
      while (((w == 0) ? cyc_a : cyc_b) != target && guard < 4000) begin
         @(negedge clk);
         guard++;
      end
      check("wait_cyc", (w == 0) ? cyc_a : cyc_b, target);
   endtask

   task automatic run_row(input vec_t v);
      int exp_err = 0;
      int first = 0;
      build_pattern(v.mode);
      exp_q.delete();
      cap_q.delete();
      for (int i = 0; i < v.exp_bits; i++) exp_q.push_back(pat[i]);
      for (int i = 0; i < 1024; i++) begin
         flip_a[i] = (v.kind == 1) ? 1'b1 : (v.kind == 3) ? ($urandom_range(0, 1) != 0) : 1'b0;
         if (i < v.exp_bits) exp_err += (v.kind == 2) ? int'(pat[i]) : int'(flip_a[i]);
      end
      if (v.exp_err >= 0) exp_err = v.exp_err;
      force0_a     = (v.kind == 2);
      if_a.mode    = v.mode;
      if_a.test_len = 10'(v.len);
      if_a.run     = 1'b0;
      mon_a        = 1'b1;
      pulse_start(0);
      for (int i = 0; i < v.exp_bits * 8 + 50; i++) begin
         if (if_a.done) break;
         @(negedge clk);
      end
      check("done", 32'(if_a.done), 1);
      check("busy_at_done", 32'(if_a.busy), 0);
      check("tx_idle_done", 32'(if_a.tx_out), 0);
      mon_a = 1'b0;
      check("err_count", if_a.err_count, exp_err);
      check("bit_count", if_a.bit_count, v.exp_bits);
      check("tx_bits_seen", cap_q.size(), v.exp_bits);
      if (v.n_first > 0 && cap_q.size() >= v.n_first) begin
         for (int i = 0; i < v.n_first; i++) first = (first << 1) | int'(cap_q[i]);
         check("first_bits", first, v.first);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int ones = 0;
      int exp6 = 0;
      int len;
      logic m;
      rst_a = 1'b0; rst_bc = 1'b0;
      if_a.start_n = 1'b1; if_b.start_n = 1'b1; if_c.start_n = 1'b1;
      if_a.run = 1'b0; if_b.run = 1'b0; if_c.run = 1'b0;
      if_a.mode = 1'b0; if_b.mode = 1'b0; if_c.mode = 1'b0;
      if_a.test_len = '0; if_b.test_len = '0; if_c.test_len = '0;
      for (int i = 0; i < 1024; i++) flip_a[i] = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(if_a.tx_out), 0);
      check("rst_err", if_a.err_count, 0);
      check("rst_bits", if_a.bit_count, 0);
      check("rst_busy", 32'(if_a.busy), 0);
      check("rst_done", 32'(if_a.done), 0);
      check("rst_state", 32'(if_a.state), 32'(IDLE));
      rst_a = 1'b1; rst_bc = 1'b1;
      repeat (2) @(negedge clk);

      // model sanity: one PRBS7 period holds 64 ones
      build_pattern(MODE_PRBS7);
      for (int i = 0; i < 127; i++) ones += int'(pat[i]);
      check("prbs_ones", ones, 64);

      vecs.push_back('{1'b1, 254, 0,   0, 254, 0, 0});
      vecs.push_back('{1'b0, 100, 1, 100, 100, 1, 1});
      vecs.push_back('{1'b1, 127, 2,  64, 127, 7, 1});
      vecs.push_back('{1'b1,   0, 1,   1,   1, 0, 0});
      vecs.push_back('{1'b0,   1, 0,   0,   1, 0, 0});
      for (int r = 0; r < 4; r++) begin
         m   = ($urandom_range(0, 1) != 0);
         len = $urandom_range(2, 60);
         vecs.push_back('{m, len, 3, -1, len, 0, 0});
      end
      foreach (vecs[i]) run_row(vecs[i]);

      // loop delay of two bit periods
      if_b.mode = MODE_PRBS7; if_b.test_len = 10'd50; if_b.run = 1'b0;
      pulse_start(1);
      wait_cyc(1, 13);
      check("ld2_no_cmp_p1", if_b.bit_count, 0);
      wait_cyc(1, 21);
      check("ld2_cmp_p2", if_b.bit_count, 1);
      for (int i = 0; i < 600 && !if_b.done; i++) @(negedge clk);
      check("ld2_done", 32'(if_b.done), 1);
      check("ld2_err", if_b.err_count, 0);
      check("ld2_bits", if_b.bit_count, 50);

      // 4-bit counters saturating in continuous mode
      if_c.mode = MODE_ALT; if_c.test_len = '0; if_c.run = 1'b1;
      pulse_start(2);
      repeat (20 * 8) @(negedge clk);
      check("sat_err", if_c.err_count, 15);
      check("sat_bits", if_c.bit_count, 15);
      check("sat_flag", 32'(if_c.err_sat), 1);
      check("sat_busy", 32'(if_c.busy), 1);
      if_c.run = 1'b0;
      for (int i = 0; i < 20 && !if_c.done; i++) @(negedge clk);
      check("sat_done", 32'(if_c.done), 1);
      pulse_start(2);
      check("restart_busy", 32'(if_c.busy), 1);
      check("restart_err", if_c.err_count, 0);
      check("restart_bits", if_c.bit_count, 0);
      check("restart_sat", 32'(if_c.err_sat), 0);

      // start ignored while running, then asynchronous reset mid-run
      for (int i = 0; i < 1024; i++) flip_a[i] = ($urandom_range(0, 1) != 0);
      for (int i = 0; i < 37; i++) exp6 += int'(flip_a[i]);
      force0_a = 1'b0;
      if_a.mode = ($urandom_range(0, 1) != 0); if_a.test_len = 10'd200; if_a.run = 1'b0;
      pulse_start(0);
      wait_cyc(0, 10 * 8 + 2);
      pulse_start(0);
      wait_cyc(0, 20 * 8 + 6);
      check("no_restart_bits", if_a.bit_count, 21);
      check("no_restart_busy", 32'(if_a.busy), 1);
      wait_cyc(0, 37 * 8 + 2);
      check("pre_reset_bits", if_a.bit_count, 37);
      check("pre_reset_err", if_a.err_count, exp6);
      @(posedge clk);
      #2 rst_a = 1'b0;
      #1;
      check("arst_tx", 32'(if_a.tx_out), 0);
      check("arst_err", if_a.err_count, 0);
      check("arst_bits", if_a.bit_count, 0);
      check("arst_busy", 32'(if_a.busy), 0);
      check("arst_done", 32'(if_a.done), 0);
      check("arst_sat", 32'(if_a.err_sat), 0);
      check("arst_state", 32'(if_a.state), 32'(IDLE));
      @(negedge clk);
      rst_a = 1'b1;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ber_tester.md
Name: ber_tester

Overview:
Parametrised bit-error-rate tester, successor to the fixed 100 kHz square-wave noise test path. Drives a test pattern (alternating or PRBS7) onto the external noise circuit and samples the returned signal at a programmable point in each bit period. Compares the sample against the transmitted bit, delayed to match the loop latency, and counts compared bits and errors. Sits between the FPGA pins and the BCD/display path.

Parameters:
CLK_DIV, 250, clk cycles per bit period (50 MHz / 250 = 200 kbit/s); legal range >= 4
SAMPLE_OFFSET, 125, timer value at which rx is sampled; legal range 3 <= SAMPLE_OFFSET < CLK_DIV
LOOP_DELAY, 0, external loop latency in whole bit periods; legal range 0..15
COUNT_W, 10, width of err_count and bit_count

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start_n  in  1  active-low start button; 2-flop synchronised; falling edge = start event
run  in  1  continuous mode; level
mode  in  1  0 = alternating 1,0,1,0…; 1 = PRBS7
test_len  in  COUNT_W  bits to compare; 0 = unbounded
rx_in  in  1  returned noisy signal; asynchronous; 2-flop synchronised
tx_out  out  1  pattern bit to noise circuit; registered
err_count  out  COUNT_W  mismatches; saturating
bit_count  out  COUNT_W  compared bits; saturating
busy  out  1  high in RUN
done  out  1  high in DONE
err_sat  out  1  sticky; set when err_count saturates

Behaviour:
- Reset (async, reset_n=0): tx_out=0, err_count=0, bit_count=0, busy=0, done=0, err_sat=0, FSM=IDLE, timer=0, PRBS state=7'h7F, delay line cleared, launch counter=0. All take effect immediately, mid-operation included.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on a start event. Same cycle: clear both counts and err_sat, latch mode, seed PRBS to 7'h7F, set timer=0, clear launch counter. busy=1 from the next cycle.
- RUN:
  - Timer counts 0..CLK_DIV-1 and wraps.
  - At timer==0: launch the next pattern bit. tx_out updates on that edge. The bit is pushed into a LOOP_DELAY+1-deep expected-bit shift register. Launch counter increments, saturating at 16.
  - At timer==SAMPLE_OFFSET: if launch counter > LOOP_DELAY, compare the synced rx with the bit launched LOOP_DELAY periods before the current one. bit_count increments; err_count increments on mismatch. Both saturate at all-ones. err_sat is set when err_count reaches all-ones.
  - Termination is evaluated at each compare using the post-increment bit_count. If run==0 and (test_len==0 or bit_count >= test_len), go to DONE on the next edge.
  - run==1 suppresses termination.
  - Start events in RUN are ignored.
  - Changes to mode mid-run are ignored. Changes to test_len take effect at the next compare.
- DONE: done=1, busy=0, tx_out=0, counts held. A start event re-enters RUN with counts cleared, as from IDLE.
- IDLE/DONE: tx_out=0, timer held at 0.
- Pattern generation:
  - Alternating: first bit 1, then toggles each period.
  - PRBS7 (x^7+x^6+1): new = s[6]^s[5]; s <= {s[5:0], new}; tx bit = new. From seed 7F the first bits are 0,0,0,0,0,0,1. Period 127, containing 64 ones.
- Latency: tx_out is valid 1 cycle after timer==0. The rx synchroniser adds 2 cycles, hence SAMPLE_OFFSET >= 3 for direct loopback.
- Simultaneous start event and async reset: reset wins.

Decomposition:
- Shared package ber_pkg:
  - FSM state enum (IDLE/RUN/DONE)
  - mode constants MODE_ALT=0, MODE_PRBS7=1
  - PRBS7 seed 7'h7F and tap positions
- One sub-module, ber_pattern_gen. It takes clk, reset_n, a load (seed) strobe, an advance strobe and mode, and outputs the pattern bit. The top holds the FSM, timer, synchronisers, delay line and counters.

Test Plan:
1. CLK_DIV=8, SAMPLE_OFFSET=4, mode=1, test_len=254, rx_in=tx_out -> done=1 after 254 compares; bit_count=254; err_count=0; busy low in the same cycle done rises.
2. Same parameters, rx_in=~tx_out, mode=0, test_len=100 -> err_count=100, bit_count=100; first tx_out bit after start = 1.
3. rx_in stuck at 0, mode=1, test_len=127 -> err_count=64; first 7 tx bits = 0,0,0,0,0,0,1.
4. LOOP_DELAY=2, rx_in = tx_out delayed 2 bit periods, test_len=50 -> err_count=0, bit_count=50. The first compare occurs in the third launched bit period.
5. COUNT_W=4, rx_in=~tx_out, run=1, test_len=0 -> err_count stops at 15, err_sat=1, bit_count stops at 15. Deassert run -> DONE after the next compare; a start event then clears the counts and err_sat.
6. reset_n=0 mid-RUN (bit 37) -> all outputs 0 immediately with no clock. A start event pulsed during RUN (before the reset) -> no restart, counts continue.
